// File: rtl/core_seq.sv
// Instruction sequencer for one attention tile: fills qmem/kmem from a stream,
// loads keys, executes all queries and drains the ofifo into pmem.
module core_seq #(
  parameter int col = 8,
  parameter int bw  = 8,
  parameter int pr  = 8,
  parameter int n_q = 16,
  parameter int aw  = 4,
  parameter int gap = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [pr*bw-1:0]    data_in,
  input  logic                data_valid,
  output logic                data_ready,
  input  logic                ofifo_valid,
  output logic [18:0]         core_inst,
  output logic [pr*bw-1:0]    core_mem_in,
  output logic                busy,
  output logic                done,
  output logic [2:0]          state_dbg
);

  // Handshake: a data beat transfers in any cycle where data_valid && data_ready
  // at the rising edge; data_ready depends only on the state register.

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_QWR   = 3'd1,
    S_KWR   = 3'd2,
    S_KLOAD = 3'd3,
    S_GAP   = 3'd4,
    S_EXEC  = 3'd5,
    S_ORD   = 3'd6,
    S_DONE  = 3'd7
  } state_t;

  localparam int gw = (gap > 1) ? $clog2(gap) : 1;
  localparam logic [aw-1:0] q_last = aw'(n_q - 1);
  localparam logic [aw-1:0] k_last = aw'(col - 1);
  localparam logic [gw-1:0] g_last = gw'(gap - 1);

  state_t             state, nxt_state;
  logic [aw-1:0]      cnt, nxt_cnt;
  logic [gw-1:0]      gap_cnt, nxt_gap;
  logic [18:0]        nxt_inst;
  logic [pr*bw-1:0]   nxt_mem;
  logic               nxt_done;
  logic               beat;

  assign data_ready = (state == S_QWR) || (state == S_KWR);
  assign beat       = data_valid && data_ready;
  assign state_dbg  = state;

  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_gap   = gap_cnt;
    nxt_inst  = '0;
    nxt_mem   = core_mem_in;
    nxt_done  = 1'b0;
    case (state)
      S_IDLE: if (start) nxt_state = S_QWR;
      S_QWR: begin
        if (beat) begin
          nxt_inst[4]     = 1'b1;
          nxt_inst[15:12] = 4'(cnt);
          nxt_mem         = data_in;
          if (cnt == q_last) nxt_state = S_KWR;
          else               nxt_cnt   = cnt + 1'b1;
        end
      end
      S_KWR: begin
        if (beat) begin
          nxt_inst[2]     = 1'b1;
          nxt_inst[15:12] = 4'(cnt);
          nxt_mem         = data_in;
          if (cnt == k_last) nxt_state = S_KLOAD;
          else               nxt_cnt   = cnt + 1'b1;
        end
      end
      S_KLOAD: begin
        nxt_inst[6]     = 1'b1;
        nxt_inst[3]     = 1'b1;
        nxt_inst[15:12] = 4'(cnt);
        if (cnt == k_last) nxt_state = S_GAP;
        else               nxt_cnt   = cnt + 1'b1;
      end
      S_GAP: begin
        if (gap_cnt == g_last) nxt_state = S_EXEC;
        else                   nxt_gap   = gap_cnt + 1'b1;
      end
      S_EXEC: begin
        nxt_inst[7]     = 1'b1;
        nxt_inst[5]     = 1'b1;
        nxt_inst[15:12] = 4'(cnt);
        if (cnt == q_last) nxt_state = S_ORD;
        else               nxt_cnt   = cnt + 1'b1;
      end
      S_ORD: begin
        // A stalled ofifo simply holds the read address until data shows up.
        if (ofifo_valid) begin
          nxt_inst[16]   = 1'b1;
          nxt_inst[0]    = 1'b1;
          nxt_inst[11:8] = 4'(cnt);
          if (cnt == q_last) nxt_state = S_DONE;
          else               nxt_cnt   = cnt + 1'b1;
        end
      end
      S_DONE: begin
        nxt_done  = 1'b1;
        nxt_state = S_IDLE;
      end
      default: nxt_state = S_IDLE;
    endcase
    if (nxt_state != state) begin
      nxt_cnt = '0;
      nxt_gap = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      gap_cnt     <= '0;
      core_inst   <= '0;
      core_mem_in <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= nxt_state;
      cnt         <= nxt_cnt;
      gap_cnt     <= nxt_gap;
      core_inst   <= nxt_inst;
      core_mem_in <= nxt_mem;
      busy        <= (nxt_state != S_IDLE);
      done        <= nxt_done;
    end
  end

endmodule

// File: tb/tb_core_seq.sv
// Directed testbench for core_seq: reset, full tiles, backpressure, ofifo
// stall, start-while-busy and reset mid-EXEC.
module tb_core_seq;

  localparam int col = 8;
  localparam int bw  = 8;
  localparam int pr  = 8;
  localparam int n_q = 16;
  localparam int aw  = 4;
  localparam int gap = 2;
  localparam int W   = pr * bw;

  localparam logic [18:0] I_QWR = 19'h00010;
  localparam logic [18:0] I_KWR = 19'h00004;
  localparam logic [18:0] I_KLD = 19'h00048;
  localparam logic [18:0] I_EXE = 19'h000a0;
  localparam logic [18:0] I_ORD = 19'h10001;

  logic          clk = 1'b0;
  logic          reset, start, data_valid, ofifo_valid;
  logic [W-1:0]  data_in;
  logic          data_ready, busy, done;
  logic [18:0]   core_inst;
  logic [W-1:0]  core_mem_in;
  logic [2:0]    state_dbg;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int tiles = 0;
  logic [W-1:0] last_mem = '0;
  logic [W-1:0] exp_q[$];

  core_seq #(.col(col), .bw(bw), .pr(pr), .n_q(n_q), .aw(aw), .gap(gap)) dut (
    .clk(clk), .reset(reset), .start(start), .data_in(data_in),
    .data_valid(data_valid), .data_ready(data_ready), .ofifo_valid(ofifo_valid),
    .core_inst(core_inst), .core_mem_in(core_mem_in), .busy(busy),
    .done(done), .state_dbg(state_dbg)
  );

  // clock / reset block
  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [18:0] qk(input logic [18:0] base, input int addr);
    return base | (19'(addr) << 12);
  endfunction

  function automatic logic [W-1:0] rnd();
    return {$urandom, $urandom};
  endfunction

  // Drives one tile from start; abort_at >= 0 pulls reset at that EXEC address.
  task automatic run_tile(input bit toggle, input int stall_at, input int stall_len,
                          input bit start_in_exec, input int abort_at);
    logic [W-1:0] d;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy", W'(busy), W'(1));
    chk("start_state", W'(state_dbg), W'(1));
    chk("start_ready", W'(data_ready), W'(1));
    chk("start_inst", W'(core_inst), '0);
    for (int i = 0; i < n_q; i++) begin
      if (toggle) begin
        data_valid = 1'b0;
        data_in = rnd();
        tick();
        chk("qwr_idle_inst", W'(core_inst), '0);
        chk("qwr_idle_mem", core_mem_in, last_mem);
      end
      d = rnd();
      exp_q.push_back(d);
      data_valid = 1'b1;
      data_in = d;
      tick();
      chk("qwr_inst", W'(core_inst), W'(qk(I_QWR, i)));
      chk("qwr_mem", core_mem_in, exp_q.pop_front());
      last_mem = d;
    end
    data_valid = 1'b0;
    for (int i = 0; i < col; i++) begin
      d = rnd();
      exp_q.push_back(d);
      data_valid = 1'b1;
      data_in = d;
      tick();
      chk("kwr_inst", W'(core_inst), W'(qk(I_KWR, i)));
      chk("kwr_mem", core_mem_in, exp_q.pop_front());
      last_mem = d;
    end
    // keep offering beats: none may be consumed outside QWR/KWR
    data_in = rnd();
    for (int i = 0; i < col; i++) begin
      tick();
      chk("kload_inst", W'(core_inst), W'(qk(I_KLD, i)));
      chk("kload_mem", core_mem_in, last_mem);
      chk("kload_ready", W'(data_ready), '0);
    end
    data_valid = 1'b0;
    for (int i = 0; i < gap; i++) begin
      tick();
      chk("gap_inst", W'(core_inst), '0);
    end
    for (int i = 0; i < n_q; i++) begin
      if (start_in_exec && i == 4) start = 1'b1;
      tick();
      start = 1'b0;
      chk("exec_inst", W'(core_inst), W'(qk(I_EXE, i)));
      if (i == abort_at) begin
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("abort_inst", W'(core_inst), '0);
        chk("abort_busy", W'(busy), '0);
        chk("abort_done", W'(done), '0);
        chk("abort_ready", W'(data_ready), '0);
        chk("abort_state", W'(state_dbg), '0);
        chk("abort_mem", core_mem_in, '0);
        last_mem = '0;
        return;
      end
    end
    ofifo_valid = 1'b1;
    for (int i = 0; i < n_q; i++) begin
      if (i == stall_at) begin
        ofifo_valid = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          tick();
          chk("ord_stall_inst", W'(core_inst), '0);
          chk("ord_stall_done", W'(done), '0);
        end
        ofifo_valid = 1'b1;
      end
      tick();
      chk("ord_inst", W'(core_inst), W'(I_ORD | (19'(i) << 8)));
    end
    ofifo_valid = 1'b0;
    chk("pre_done", W'(done), '0);
    chk("pre_done_busy", W'(busy), W'(1));
    tick();
    chk("done_pulse", W'(done), W'(1));
    chk("done_busy", W'(busy), '0);
    chk("done_inst", W'(core_inst), '0);
    tick();
    chk("done_clear", W'(done), '0);
    chk("done_state", W'(state_dbg), '0);
    tiles++;
    chk("done_count", W'(done_cnt), W'(tiles));
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b1;
    data_valid = 1'b0;
    ofifo_valid = 1'b0;
    data_in = '0;
    repeat (3) tick();
    chk("rst_inst", W'(core_inst), '0);
    chk("rst_mem", core_mem_in, '0);
    chk("rst_busy", W'(busy), '0);
    chk("rst_done", W'(done), '0);
    chk("rst_ready", W'(data_ready), '0);
    chk("rst_state", W'(state_dbg), '0);
    reset = 1'b1;

    run_tile(1'b0, -1, 0, 1'b0, -1);  // continuous valid, 66 strobe cycles
    run_tile(1'b1, -1, 0, 1'b0, -1);  // data_valid toggling in QWR
    run_tile(1'b0, 7, 5, 1'b1, -1);   // ofifo stall at read 7, start during EXEC
    run_tile(1'b0, -1, 0, 1'b0, 9);   // reset mid-EXEC at address 9
    chk("abort_done_count", W'(done_cnt), W'(tiles));
    run_tile(1'b0, -1, 0, 1'b0, -1);  // clean tile after abort

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/core_seq.md
# core_seq

Instruction sequencer that drives the core's 19-bit instruction word and activation-memory input for one complete attention tile. It streams query and key vectors from an external source into qmem/kmem, then loads the keys into the array, executes all queries, and drains the ofifo into pmem. It sits between the host/testbench stimulus and the core instance, replacing hand-written instruction sequences with a start/busy/done handshake.

## Interface
- col, 8, array columns; number of key vectors loaded
- bw, 8, activation bit width
- pr, 8, elements per memory word
- n_q, 16, number of query vectors per tile
- aw, 4, memory address width; requires n_q ≤ 2^aw and col ≤ 2^aw
- gap, 2, idle cycles between KLOAD and EXEC (pipeline settle)

Ports:
- clk  in  1  clock; all logic on the rising edge
- reset  in  1  synchronous, active-low (reset==0 resets)
- start  in  1  begin tile; sampled only in IDLE
- data_in  in  pr*bw  query/key vector from the source
- data_valid  in  1  data_in valid
- data_ready  out  1  sequencer accepts data_in this cycle
- ofifo_valid  in  1  core ofifo holds at least one psum row
- core_inst  out  19  instruction word to the core
- core_mem_in  out  pr*bw  memory data to the core
- busy  out  1  high from start accept until DONE exits
- done  out  1  one-cycle pulse at tile completion

## Operation
- core_inst fields: [18:17] reserved, always 0; [16] ofifo_rd; [15:12] qkmem_add; [11:8] pmem_add; [7] execute; [6] load; [5] qmem_rd; [4] qmem_wr; [3] kmem_rd; [2] kmem_wr; [1] pmem_rd (always 0); [0] pmem_wr.
- Single address counter `cnt` (aw bits) and gap counter. Both clear on every state transition.
- States and transitions:
  - IDLE: start → QWR.
  - QWR: data_ready=1. On each beat (data_valid & data_ready): qmem_wr=1, qkmem_add=cnt, core_mem_in=data_in, cnt++. After beat n_q-1 → KWR.
  - KWR: same as QWR with kmem_wr. After beat col-1 → KLOAD.
  - KLOAD: one row per cycle, no stall. kmem_rd=1, load=1, qkmem_add=cnt. After cnt=col-1 → GAP.
  - GAP: all strobes 0 for gap cycles, then → EXEC.
  - EXEC: qmem_rd=1, execute=1, qkmem_add=cnt, one per cycle. After cnt=n_q-1 → ORD.
  - ORD: in each cycle with ofifo_valid=1: ofifo_rd=1, pmem_wr=1, pmem_add=cnt, cnt++. Strobes are 0 when ofifo_valid=0. After read n_q-1 → DONE.
  - DONE: done=1 for one cycle, then → IDLE.
- data_ready is 0 outside QWR/KWR. Beats offered elsewhere are not consumed.
- start while busy is ignored. Beats without data_valid leave all strobes 0 and hold cnt.
- Any field not listed for a state is 0.
- core_mem_in holds its last value when no write beat occurs.

## Timing
- core_inst, core_mem_in, busy and done are registered.
- A beat accepted at edge k, or any state action decided at edge k, appears on the outputs during cycle k+1.
- Start accepted at edge 0: busy=1 from cycle 1. The first QWR beat can be accepted at edge 1.
- With continuous data_valid and ofifo_valid, the sequence takes n_q + col + col + gap + n_q + n_q cycles of strobes. done is high in the following cycle.
- Reset (reset==0 at an edge) forces the following in the next cycle from any state, including mid-EXEC or mid-ORD: state=IDLE, core_inst=0, core_mem_in=0, busy=0, done=0, data_ready=0, cnt=0.
- Address wrap is not permitted: cnt never exceeds max(n_q, col)-1.

## Test plan
- Reset: hold reset=0 for 3 cycles with start=1 → all outputs 0 and state IDLE. Release reset → busy rises 1 cycle after the start edge.
- Full tile, defaults, continuous valid: 16 Q beats (qmem_wr, addr 0..15), then 8 K beats, then 8 load cycles (addr 0..7), then 2 idle cycles, then 16 execute cycles, then 16 ofifo_rd/pmem_wr cycles (pmem_add 0..15) → done pulse exactly once. Total 66 strobe cycles.
- Backpressure: toggle data_valid 1-0-1-0 in QWR → exactly 16 qmem_wr pulses with contiguous addresses 0..15. core_mem_in matches each accepted data_in.
- ofifo stall: drop ofifo_valid for 5 cycles at ORD read 7 → no ofifo_rd/pmem_wr during the stall. Reading resumes at pmem_add=7, and done is delayed 5 cycles.
- start pulsed during EXEC → ignored: no restart and the done count stays 1.
- reset=0 mid-EXEC at qkmem_add=9 → next cycle core_inst=0 and busy=0. A new start then runs a clean full tile from QWR addr 0.
